// File: rtl/adc_data_input.sv
// Multi-lane serial deserialiser for a sigma-delta ADC: each nDRDY falling edge
// starts a frame, every DOUT lane shifts FRAME_BITS bits MSB-first into its DATA word.
module adc_data_input #(
    parameter int LANES      = 4,
    parameter int FRAME_BITS = 64
) (
    input  logic                  MCLK,
    input  logic                  RST,
    input  logic                  nSYNC_IN,
    input  logic                  nDRDY,
    input  logic [LANES-1:0]      DOUT,
    output logic                  DATA_READY,
    output logic [FRAME_BITS-1:0] DATA [LANES-1:0]
);

    localparam int CW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         w_countNext;
    logic                  r_ndrdyQ;
    logic                  r_ready;
    logic                  w_fall;
    logic                  w_shift;
    logic                  w_load;
    logic [FRAME_BITS-1:0] r_sreg [LANES-1:0];
    logic [FRAME_BITS-1:0] r_data [LANES-1:0];

    assign w_fall = ~nDRDY & r_ndrdyQ;

    // A falling edge mid-frame restarts the count; on the last bit it both
    // completes the frame and opens the next one.
    always_comb begin
        w_stateNext = r_state;
        w_countNext = r_count;
        w_shift     = 1'b0;
        w_load      = 1'b0;
        if (!nSYNC_IN) begin
            w_stateNext = IDLE;
            w_countNext = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        w_stateNext = SHIFT;
                        w_countNext = '0;
                    end
                end
                SHIFT: begin
                    if (r_count == LAST_BIT) begin
                        w_shift     = 1'b1;
                        w_load      = 1'b1;
                        w_countNext = '0;
                        w_stateNext = w_fall ? SHIFT : IDLE;
                    end else if (w_fall) begin
                        w_countNext = '0;
                    end else begin
                        w_shift     = 1'b1;
                        w_countNext = r_count + CW'(1);
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                    w_countNext = '0;
                end
            endcase
        end
    end

    always_ff @(posedge MCLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_ndrdyQ <= 1'b0;
            r_ready  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_sreg[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_state  <= w_stateNext;
            r_count  <= w_countNext;
            r_ndrdyQ <= nDRDY;
            r_ready  <= w_load;
            for (int i = 0; i < LANES; i++) begin
                if (w_shift) begin
                    r_sreg[i] <= {r_sreg[i][FRAME_BITS-2:0], DOUT[i]};
                end
                if (w_load) begin
                    r_data[i] <= {r_sreg[i][FRAME_BITS-2:0], DOUT[i]};
                end
            end
        end
    end

    assign DATA_READY = r_ready;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            DATA[i] = r_data[i];
        end
    end

endmodule

// File: tb/tb_adc_data_input.sv
// Directed bench for adc_data_input: expected frames go into a scoreboard queue
// when driven and are compared against DATA when DATA_READY pulses.
module tb_adc_data_input;

    logic        MCLK = 1'b0;
    logic        RST;
    logic        nSYNC_IN;
    logic        nDRDY;
    logic [3:0]  dout;
    logic        dataReady;
    logic [63:0] data [3:0];

    typedef struct {
        logic [3:0][63:0] data;
        int               cyc;
    } exp_t;

    exp_t             sb[$];
    logic [3:0][63:0] modelData;
    int               checks   = 0;
    int               failures = 0;
    int               cyc      = 0;
    logic             prevReady = 1'b0;

    adc_data_input #(.LANES(4), .FRAME_BITS(64)) dut (
        .MCLK       (MCLK),
        .RST        (RST),
        .nSYNC_IN   (nSYNC_IN),
        .nDRDY      (nDRDY),
        .DOUT       (dout),
        .DATA_READY (dataReady),
        .DATA       (data)
    );

    always #61 MCLK = ~MCLK;

    always @(posedge MCLK) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkLanes(input string tag, input logic [3:0][63:0] exp);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("%s_lane%0d", tag, i), data[i], exp[i]);
    endtask

    // Scoreboard consumer: each ready pulse must match the oldest pending frame.
    always @(negedge MCLK) begin
        if (cyc > 0) begin
            checks++;
            assert (!(dataReady === 1'b1 && prevReady === 1'b1)) else begin
                failures++;
                $error("[TB] FAIL ready_double: observed=1 expected=0 at cycle %0d", cyc);
            end
            if (dataReady === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $error("[TB] FAIL unexpected_ready: observed=1 expected=0 at cycle %0d", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("ready_latency", 64'(cyc), 64'(e.cyc));
                    checkLanes("frame", e.data);
                    modelData = e.data;
                end
            end
            prevReady = dataReady;
        end
    end

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic pushExp(input logic [3:0][63:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic startEdge();
        nDRDY = 1'b0;
        tick();
        nDRDY = 1'b1;
    endtask

    task automatic shiftBits(input logic [3:0][63:0] d, input int first, input int n);
        for (int b = 0; b < n; b++) begin
            for (int i = 0; i < 4; i++) dout[i] = d[i][63-(first+b)];
            tick();
        end
    endtask

    task automatic applyStimulus(input logic [3:0][63:0] d);
        pushExp(d, cyc + 65);
        startEdge();
        shiftBits(d, 0, 64);
        tick();
    endtask

    initial begin
        logic [3:0][63:0] d;
        logic [3:0][63:0] d2;
        logic [3:0][63:0] junk;
        logic [3:0][63:0] zero;

        zero      = '0;
        modelData = '0;
        RST       = 1'b1;
        nSYNC_IN  = 1'b1;
        nDRDY     = 1'bx;
        dout      = 4'h0;
        repeat (4) tick();
        nDRDY = 1'b1;
        repeat (4) tick();
        checkLanes("reset", zero);
        checkOutput("reset_ready", 64'(dataReady), 64'd0);

        // Release with nDRDY already low must not start a frame.
        nDRDY = 1'b0;
        tick();
        RST = 1'b0;
        repeat (80) tick();
        nDRDY = 1'b1;
        repeat (4) tick();
        checkLanes("release_low", zero);

        $display("[TB] constant lanes");
        d[3] = '1; d[2] = '0; d[1] = '1; d[0] = '0;
        applyStimulus(d);
        checkOutput("ready_deassert", 64'(dataReady), 64'd0);

        $display("[TB] bit order");
        d[0] = 64'h8000_0000_0000_0000;
        d[3] = 64'h0000_0000_0000_0001;
        d[1] = {$urandom, $urandom};
        d[2] = {$urandom, $urandom};
        applyStimulus(d);
        checkLanes("bitorder_hold", d);

        $display("[TB] successive frames");
        d[3] = '1; d[2] = '1; d[1] = '1; d[0] = '1;
        pushExp(d, cyc + 65);
        startEdge();
        shiftBits(d, 0, 64);
        d[2] = '0; d[1] = '0; d[0] = '0;
        applyStimulus(d);
        repeat (64000) tick();
        checkLanes("idle_hold", d);

        $display("[TB] nSYNC abort");
        junk[0] = {$urandom, $urandom}; junk[1] = {$urandom, $urandom};
        junk[2] = {$urandom, $urandom}; junk[3] = {$urandom, $urandom};
        startEdge();
        shiftBits(junk, 0, 30);
        nSYNC_IN = 1'b0;
        repeat (2) tick();
        nSYNC_IN = 1'b1;
        shiftBits(junk, 32, 32);
        repeat (10) tick();
        checkLanes("sync_abort_hold", d);

        $display("[TB] restart on second edge");
        startEdge();
        shiftBits(junk, 0, 20);
        d[0] = {$urandom, $urandom}; d[1] = {$urandom, $urandom};
        d[2] = {$urandom, $urandom}; d[3] = {$urandom, $urandom};
        applyStimulus(d);
        checkLanes("restart_hold", d);

        $display("[TB] back-to-back on last bit");
        d2[0] = {$urandom, $urandom}; d2[1] = {$urandom, $urandom};
        d2[2] = {$urandom, $urandom}; d2[3] = {$urandom, $urandom};
        pushExp(d, cyc + 65);
        startEdge();
        shiftBits(d, 0, 63);
        pushExp(d2, cyc + 65);
        nDRDY = 1'b0;
        shiftBits(d, 63, 1);
        nDRDY = 1'b1;
        shiftBits(d2, 0, 64);
        tick();
        checkLanes("b2b_hold", d2);

        $display("[TB] reset mid-frame");
        startEdge();
        shiftBits(junk, 0, 40);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        modelData = '0;
        checkLanes("midreset", zero);
        checkOutput("midreset_ready", 64'(dataReady), 64'd0);
        shiftBits(junk, 40, 24);
        repeat (4) tick();
        checkLanes("midreset_hold", zero);
        d[0] = 64'h0123_4567_89AB_CDEF; d[1] = 64'hFEDC_BA98_7654_3210;
        d[2] = 64'hA5A5_5A5A_0F0F_F0F0; d[3] = 64'h8000_0000_0000_0001;
        applyStimulus(d);

        for (int w = 0; w < 100 && sb.size() != 0; w++) tick();
        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_data_input.md
Name: adc_data_input

Overview:
Deserialiser for a 4-lane multi-channel sigma-delta ADC running from the shared 8.192 MHz MCLK. Each nDRDY falling edge starts a frame, and every DOUT lane then shifts 64 bits MSB-first. At frame end the block presents four 64-bit words, one per lane, and pulses DATA_READY for one cycle. It sits between the ADC pins and the downstream sample-processing/PMU logic.

Parameters:
LANES, 4, number of serial DOUT lanes (one DATA word per lane)
FRAME_BITS, 64, bits shifted per lane per frame (width of each DATA word)

Ports:
MCLK  input  1  system/ADC master clock (8.192 MHz); all logic on rising edge
RST  input  1  synchronous reset, active-high
nSYNC_IN  input  1  synchronous, active-low frame resync/abort
nDRDY  input  1  ADC data-ready, active-low; falling edge marks frame start
DOUT  input  LANES  serial data, bit i = lane i; synchronous to MCLK
DATA_READY  output  1  one-cycle pulse: DATA updated with a complete frame
DATA  output  LANES x FRAME_BITS  unpacked array DATA[LANES-1:0], each FRAME_BITS wide; DATA[i] from DOUT[i]

Behaviour:
- Reset (RST=1 at rising edge) has highest priority. It forces DATA[*]=0, DATA_READY=0, state=IDLE, bit counter=0, shift registers=0, and the registered nDRDY history nDRDY_q=0.
- nDRDY_q is nDRDY registered every cycle. Because it resets to 0, a low nDRDY at reset release does not start a frame.
- nDRDY and DOUT are treated as MCLK-synchronous; no metastability synchroniser is used.
- Falling edge: nDRDY==0 && nDRDY_q==1, evaluated at a rising edge (call it E0).
- States: IDLE and SHIFT.
- IDLE: on a falling edge at E0, go to SHIFT with counter=0. Otherwise stay in IDLE.
- SHIFT: on edges E1..E64, shift DOUT[i] into the LSB of sreg[i] (MSB-first ordering), one bit per cycle, and increment the counter.
- The first captured bit, at E1, becomes DATA[i][63]. The bit captured at E64 becomes DATA[i][0].
- At E64 (counter==FRAME_BITS-1), every lane updates in the same edge:
  - DATA[i] <= {sreg[i][62:0], DOUT[i]} for all i simultaneously;
  - DATA_READY <= 1;
  - state returns to IDLE.
- DATA_READY deasserts on the next edge. It is never high two cycles in a row.
- Latency: DATA_READY is high during the cycle after E64, i.e. 64 cycles after the falling edge was detected.
- DATA holds its value until the next completed frame, reset, or nothing else; nSYNC_IN does not clear it.
- nDRDY state in SHIFT: the nDRDY level is ignored during SHIFT. However, a new falling edge detected during SHIFT aborts the partial frame and restarts: counter=0, stay in SHIFT, no DATA_READY for the aborted frame.
- Back-to-back frames: a falling edge on the same edge as E64 completes the current frame (DATA_READY pulses) and immediately starts a new frame in SHIFT.
- nSYNC_IN==0 (below reset, above all else):
  - forces state to IDLE and counter to 0;
  - forces DATA_READY to 0;
  - aborts any frame in progress, with no update of DATA;
  - keeps falling edges from being honoured while low (nDRDY_q is still updated).
- Reset mid-frame: the partial frame is discarded and all outputs return to reset values.
- Long gaps with nDRDY held high: the block idles indefinitely, with no timeout.
- Counter is log2(FRAME_BITS) bits wide. It must not wrap silently: it is always cleared on frame start or abort.

Test Plan:
- Reset: RST=1 for 8 cycles with nDRDY=X/1 -> DATA[0..3]=0, DATA_READY=0. Release RST with nDRDY=0 held low -> no frame, no DATA_READY.
- Constant lanes: nDRDY 1->0 for one cycle, DOUT=4'b1010 for 64 cycles -> exactly 64 cycles later DATA_READY pulses 1 cycle. DATA[3]=64'hFFFF_FFFF_FFFF_FFFF, DATA[2]=0, DATA[1]=64'hFFFF_FFFF_FFFF_FFFF, DATA[0]=0.
- Bit order: lane 0 = 1 on the first captured bit then 0, lane 3 = 0 then 1 only on the last bit -> DATA[0]=64'h8000_0000_0000_0000, DATA[3]=64'h0000_0000_0000_0001.
- Successive frames: frames 65 cycles apart with DOUT=4'b1111 then 4'b1000 -> two single-cycle DATA_READY pulses. Final DATA[3]=all ones and DATA[2..0]=0; DATA is held during a subsequent 64000-cycle idle gap.
- Abort: nSYNC_IN=0 for 2 cycles at bit 30 -> no DATA_READY and DATA unchanged. A second nDRDY falling edge mid-frame -> restart, DATA_READY 64 cycles after the second edge.
- Reset mid-frame: assert RST at bit 40 -> DATA=0, no DATA_READY. The next full frame captures correctly.
